// File: rtl/platform_key_pio.sv
// Purpose : Avalon-MM key/switch PIO with 2-flop sync, per-bit debounce, sticky edge capture and masked irq.
// Latency : reads return one clk after the strobe; in_port reaches DATA after 2 + DEBOUNCE_CYCLES clks.
// Backpres: none; the slave accepts every access in the cycle it is presented (no waitrequest).
//
// Ports:
//   clk, reset            - single rising-edge clock, synchronous active-high reset
//   address, chipselect,
//   read_n, write_n,
//   writedata, readdata   - Avalon-MM slave (0 DATA, 1 reserved, 2 IRQMASK, 3 EDGECAP)
//   in_port               - asynchronous key/switch lines
//   irq                   - level interrupt, OR of EDGECAP & IRQMASK
module platform_key_pio #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = 1,
    parameter bit IDLE_LEVEL      = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read_n,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [WIDTH-1:0] IDLE_VEC = {WIDTH{IDLE_LEVEL}};

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] deb;
    logic [WIDTH-1:0] deb_prev;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] w1c;
    logic [31:0]      rd_mux;
    logic             rd_en;
    logic             wr_en;
    logic             unused_wdata;

    // Upper writedata bits carry no state for narrow configurations.
    assign unused_wdata = ^writedata;

    // Two-flop synchroniser, reset to the resting level so release causes no edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= IDLE_VEC;
            sync2 <= IDLE_VEC;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_no_debounce
            always_ff @(posedge clk) begin
                if (reset) begin
                    deb <= IDLE_VEC;
                end else begin
                    deb <= sync2;
                end
            end
        end else begin : g_debounce
            localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

            logic [CW-1:0] cnt [WIDTH];

            // Counter runs only while sync2 disagrees with the accepted level;
            // any agreement (glitch ending) restarts the count from zero.
            always_ff @(posedge clk) begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (reset) begin
                        cnt[i] <= '0;
                        deb[i] <= IDLE_LEVEL;
                    end else if (sync2[i] == deb[i]) begin
                        cnt[i] <= '0;
                    end else if (cnt[i] == CNT_LAST) begin
                        deb[i] <= sync2[i];
                        cnt[i] <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + CW'(1);
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            deb_prev <= IDLE_VEC;
        end else begin
            deb_prev <= deb;
        end
    end

    always_comb begin
        edge_hit = '0;
        case (EDGE_TYPE)
            0:       edge_hit = ~deb_prev & deb;
            1:       edge_hit = deb_prev & ~deb;
            default: edge_hit = deb_prev ^ deb;
        endcase
    end

    assign rd_en = chipselect & ~read_n;
    assign wr_en = chipselect & ~write_n;
    assign w1c   = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

    // Read mux sees pre-write register values, so a same-cycle read/write returns old data.
    always_comb begin
        rd_mux = '0;
        case (address)
            2'd0:    rd_mux[WIDTH-1:0] = deb;
            2'd2:    rd_mux[WIDTH-1:0] = irq_mask;
            2'd3:    rd_mux[WIDTH-1:0] = edge_cap;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_mask <= '0;
            edge_cap <= '0;
            readdata <= '0;
        end else begin
            if (wr_en && address == 2'd2) begin
                irq_mask <= writedata[WIDTH-1:0];
            end
            // Set is OR-ed in after the clear so a coincident edge survives.
            edge_cap <= (edge_cap & ~w1c) | edge_hit;
            if (rd_en) begin
                readdata <= rd_mux;
            end
        end
    end

    assign irq = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_platform_key_pio.sv
// Purpose : self-checking bench for platform_key_pio (WIDTH=4, DEBOUNCE_CYCLES=4, falling edges, idle high).
// Latency : stimulus applied #1 after a rising edge, outputs sampled #1 after the next one.
// Backpres: none; fixed cycle counts only, so the run always terminates.
module tb_platform_key_pio;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;

    platform_key_pio #(
        .WIDTH           (4),
        .DEBOUNCE_CYCLES (4),
        .EDGE_TYPE       (1),
        .IDLE_LEVEL      (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .read_n     (read_n),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    // Reference model: a line is accepted once the synchronised input has shown
    // the opposite level for the last 4 samples in a row (history window).
    logic [3:0]  m_s1, m_s2, m_deb, m_prev, m_cap, m_mask;
    logic [31:0] m_rd;
    logic [3:0]  m_hist[$];

    task automatic model_step();
        logic [3:0]  nd;
        logic [3:0]  fall;
        logic [31:0] rv;
        logic        all_diff;
        if (reset) begin
            m_s1 = 4'hF; m_s2 = 4'hF; m_deb = 4'hF; m_prev = 4'hF;
            m_cap = 4'h0; m_mask = 4'h0; m_rd = 32'h0;
            m_hist.delete();
            return;
        end
        fall = m_prev & ~m_deb;
        case (address)
            2'd0:    rv = {28'h0, m_deb};
            2'd2:    rv = {28'h0, m_mask};
            2'd3:    rv = {28'h0, m_cap};
            default: rv = 32'h0;
        endcase
        if (chipselect && !read_n) m_rd = rv;
        if (chipselect && !write_n) begin
            if (address == 2'd2) m_mask = writedata[3:0];
            if (address == 2'd3) m_cap = m_cap & ~writedata[3:0];
        end
        m_cap = m_cap | fall;
        m_hist.push_back(m_s2);
        if (m_hist.size() > 4) void'(m_hist.pop_front());
        nd = m_deb;
        if (m_hist.size() == 4) begin
            for (int b = 0; b < 4; b++) begin
                all_diff = 1'b1;
                for (int k = 0; k < 4; k++)
                    if (m_hist[k][b] == m_deb[b]) all_diff = 1'b0;
                if (all_diff) nd[b] = ~m_deb[b];
            end
        end
        m_prev = m_deb;
        m_deb  = nd;
        m_s2   = m_s1;
        m_s1   = in_port;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        address = a; chipselect = 1'b1; read_n = 1'b0;
        tick();
        chipselect = 1'b0; read_n = 1'b1;
        d = readdata;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        tick();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    typedef struct {
        bit          is_write;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic [31:0] rd;

        vecs[0]  = '{1'b1, 2'd2, 32'h0000_0005, 32'h0};
        vecs[1]  = '{1'b0, 2'd2, 32'h0,         32'h0000_0005};
        vecs[2]  = '{1'b1, 2'd2, 32'hFFFF_FFFF, 32'h0};
        vecs[3]  = '{1'b0, 2'd2, 32'h0,         32'h0000_000F};
        vecs[4]  = '{1'b1, 2'd1, 32'hFFFF_FFFF, 32'h0};
        vecs[5]  = '{1'b0, 2'd1, 32'h0,         32'h0};
        vecs[6]  = '{1'b1, 2'd0, 32'h0,         32'h0};
        vecs[7]  = '{1'b0, 2'd0, 32'h0,         32'h0000_000F};
        vecs[8]  = '{1'b0, 2'd3, 32'h0,         32'h0};
        vecs[9]  = '{1'b1, 2'd2, 32'hFFFF_FFF0, 32'h0};
        vecs[10] = '{1'b0, 2'd2, 32'h0,         32'h0};
        vecs[11] = '{1'b0, 2'd1, 32'h0,         32'h0};

        reset = 1'b1; chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
        address = 2'd0; writedata = 32'h0; in_port = 4'hF;
        repeat (3) tick();
        check("reset_readdata", readdata, 32'h0);
        check("reset_irq", {31'h0, irq}, 32'h0);
        reset = 1'b0;
        repeat (2) tick();

        // Idle after reset
        bus_read(2'd0, rd); check("idle_data", rd, 32'hF);
        bus_read(2'd3, rd); check("idle_edgecap", rd, 32'h0);
        check("idle_irq", {31'h0, irq}, 32'h0);

        // Steady press on bit 0: accepted exactly 2 + 4 cycles later
        bus_write(2'd2, 32'h1);
        in_port = 4'hE;
        repeat (5) tick();
        bus_read(2'd0, rd); check("press_before_accept", rd, 32'hF);
        check("press_irq_early", {31'h0, irq}, 32'h0);
        bus_read(2'd0, rd); check("press_data", rd, 32'hE);
        bus_read(2'd3, rd); check("press_edgecap", rd, 32'h1);
        check("press_irq", {31'h0, irq}, 32'h1);

        // 3-cycle glitch is rejected, 4-cycle pulse is accepted
        in_port = 4'hC; repeat (3) tick();
        in_port = 4'hE; repeat (8) tick();
        bus_read(2'd0, rd); check("glitch3_data", rd, 32'hE);
        bus_read(2'd3, rd); check("glitch3_edgecap", rd, 32'h1);
        in_port = 4'hC; repeat (4) tick();
        in_port = 4'hE; repeat (12) tick();
        bus_read(2'd3, rd); check("pulse4_edgecap", rd, 32'h3);
        bus_read(2'd0, rd); check("pulse4_data", rd, 32'hE);

        // Write-1-to-clear drops the masked bit and irq immediately after
        bus_write(2'd2, 32'h2);
        check("mask2_irq", {31'h0, irq}, 32'h1);
        bus_write(2'd3, 32'h2);
        check("w1c_irq", {31'h0, irq}, 32'h0);
        bus_read(2'd3, rd); check("w1c_edgecap", rd, 32'h1);

        // Edge on bit 2 coincides with a clear of bit 2: set wins
        in_port = 4'hA; repeat (6) tick();
        bus_write(2'd3, 32'h4);
        bus_read(2'd3, rd); check("set_wins", rd, 32'h5);
        repeat (4) tick();
        bus_read(2'd0, rd); check("bit2_data", rd, 32'hA);

        // Simultaneous read and write return the pre-write value
        address = 2'd3; writedata = 32'h1; chipselect = 1'b1; read_n = 1'b0; write_n = 1'b0;
        tick();
        chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
        check("rw_edgecap_old", readdata, 32'h5);
        bus_read(2'd3, rd); check("rw_edgecap_new", rd, 32'h4);
        address = 2'd2; writedata = 32'hF; chipselect = 1'b1; read_n = 1'b0; write_n = 1'b0;
        tick();
        chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
        check("rw_mask_old", readdata, 32'h2);
        bus_read(2'd2, rd); check("rw_mask_new", rd, 32'hF);
        check("rw_irq", {31'h0, irq}, 32'h1);

        // Reset mid-debounce with a read pending
        bus_write(2'd3, 32'hF);
        in_port = 4'h2; repeat (4) tick();
        reset = 1'b1; address = 2'd0; chipselect = 1'b1; read_n = 1'b0;
        tick();
        reset = 1'b0; chipselect = 1'b0; read_n = 1'b1;
        check("reset_read_suppressed", readdata, 32'h0);
        check("reset_irq_mid", {31'h0, irq}, 32'h0);
        bus_read(2'd0, rd); check("post_reset_data", rd, 32'hF);
        bus_read(2'd3, rd); check("post_reset_edgecap", rd, 32'h0);
        repeat (3) tick();
        bus_read(2'd0, rd); check("restart_before_accept", rd, 32'hF);
        bus_read(2'd0, rd); check("restart_accept", rd, 32'h2);
        bus_read(2'd2, rd); check("post_reset_mask", rd, 32'h0);

        // Register-map table at rest
        in_port = 4'hF; reset = 1'b1; repeat (2) tick();
        reset = 1'b0; repeat (8) tick();
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].is_write) begin
                bus_write(vecs[i].addr, vecs[i].wdata);
            end else begin
                bus_read(vecs[i].addr, rd);
                check($sformatf("table_%0d", i), rd, vecs[i].exp);
            end
        end
        check("table_irq", {31'h0, irq}, 32'h0);

        // Randomised traffic against the reference model
        for (int c = 0; c < 4000; c++) begin
            reset      = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 7) == 0) in_port = 4'($urandom_range(0, 15));
            chipselect = 1'($urandom_range(0, 1));
            read_n     = 1'($urandom_range(0, 1));
            write_n    = ($urandom_range(0, 3) != 0);
            address    = 2'($urandom_range(0, 3));
            writedata  = $urandom;
            tick();
            check("rnd_readdata", readdata, m_rd);
            check("rnd_irq", {31'h0, irq}, {31'h0, |(m_cap & m_mask)});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
